mips32_mem_arbiter: RTL and testbench

- Arbitrates the single-port 1024x32 unified memory of the pipelined MIPS32 core between two requesters: the instruction-fetch (IF) port and the data-memory (DM) port (LW/SW).
- Issues at most one memory command per cycle and tags each read so its data returns to the owner after a fixed latency.
- Supports fetch flush on a taken branch, which kills in-flight fetch reads.

---
 rtl/mips32_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares the single-port unified memory of the MIPS32 core
// between the instruction-fetch port and the data-memory port. At most one
// command is issued per cycle. A MEM_LAT-deep tag pipe routes read data back
// to its owner, and a taken-branch flush kills fetch reads still in flight.
// Optional feature macro: MIPS32_ARB_STARVE_GUARD_EN. When it is defined, a
// fetch that has stalled for STARVE_MAX cycles is granted ahead of data.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH} state_t;

  state_t               r_state;
  logic [MEM_LAT-1:0]   r_tagV;
  logic [MEM_LAT-1:0]   w_tagF;
  logic                 w_forceIf;
  logic                 w_rdGnt;
  logic                 w_outV;
  logic                 w_outF;

  // Only 1..4 cycles of read latency are meaningful for this memory.
  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_badParams
    $error("mips32_mem_arbiter: MEM_LAT must be 1..4 and STARVE_MAX >= 1");
  end

  assign dm_gnt = dm_req & ~w_forceIf;
  assign if_gnt = if_req & (~dm_req | w_forceIf);

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = dm_gnt ? dm_wdata : '0;

  assign w_rdGnt = if_gnt | (dm_gnt & ~dm_we);

`ifdef MIPS32_ARB_STARVE_GUARD_EN
  localparam int            CW     = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_starveCnt;
  logic          w_atMax;

  assign w_atMax   = (r_starveCnt == LP_MAX);
  assign w_forceIf = w_atMax & if_req;

  // Count cycles a requesting fetch is refused; reaching the limit forces one fetch grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (if_gnt || w_atMax) begin
      r_starveCnt <= '0;
    end else if (if_req) begin
      r_starveCnt <= r_starveCnt + CW'(1);
    end
  end
`else
  assign w_forceIf = 1'b0;
`endif

  // Track the owner of the last grant; it also supplies the owner bit of the newest tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (dm_gnt) begin
      r_state <= S_DATA;
    end else if (if_gnt) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign w_tagF[0] = (r_state == S_FETCH);

  if (MEM_LAT > 1) begin : g_deepTag
    logic [MEM_LAT-1:1] r_tagF;

    // Owner bits follow the valid bits down the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tagF <= '0;
      end else begin
        r_tagF[1] <= w_tagF[0];
        for (int i = 2; i < MEM_LAT; i++) begin
          r_tagF[i] <= r_tagF[i-1];
        end
      end
    end

    assign w_tagF[MEM_LAT-1:1] = r_tagF;
  end

  // Shift read tags; a flush drops every fetch-owned tag but keeps the one granted now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tagV <= '0;
    end else begin
      r_tagV[0] <= w_rdGnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_tagV[i] <= r_tagV[i-1] & ~(if_flush & w_tagF[i-1]);
      end
    end
  end

  assign w_outV = r_tagV[MEM_LAT-1];
  assign w_outF = w_tagF[MEM_LAT-1];

  assign if_rvalid = w_outV & w_outF & ~if_flush;
  assign dm_rvalid = w_outV & ~w_outF;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
  assign busy      = |r_tagV;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Testbench for mips32_mem_arbiter: two instances (read latency 1 and 3) share
// one set of request inputs and one memory model. Directed scenarios with
// hand-computed expectations.
module tb_mips32_mem_arbiter;

  logic        clk;
  logic        rstN;
  logic        ifReq;
  logic [9:0]  ifAddr;
  logic        ifFlush;
  logic        dmReq;
  logic        dmWe;
  logic [9:0]  dmAddr;
  logic [31:0] dmWdata;

  logic        d1IfGnt, d1IfRvalid, d1DmGnt, d1DmRvalid, d1MemEn, d1MemWe, d1Busy;
  logic [31:0] d1IfRdata, d1DmRdata, d1MemWdata, d1MemRdata;
  logic [9:0]  d1MemAddr;

  logic        d3IfGnt, d3IfRvalid, d3DmGnt, d3DmRvalid, d3MemEn, d3MemWe, d3Busy;
  logic [31:0] d3IfRdata, d3DmRdata, d3MemWdata, d3MemRdata;
  logic [9:0]  d3MemAddr;

  logic [31:0] mem [1024];
  logic [31:0] d3Pipe [3];

  int nChecks = 0;
  int nFails  = 0;

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst_n(rstN),
    .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush), .if_gnt(d1IfGnt),
    .if_rvalid(d1IfRvalid), .if_rdata(d1IfRdata),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_gnt(d1DmGnt), .dm_rvalid(d1DmRvalid), .dm_rdata(d1DmRdata),
    .mem_en(d1MemEn), .mem_we(d1MemWe), .mem_addr(d1MemAddr), .mem_wdata(d1MemWdata),
    .mem_rdata(d1MemRdata), .busy(d1Busy)
  );

  mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst_n(rstN),
    .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush), .if_gnt(d3IfGnt),
    .if_rvalid(d3IfRvalid), .if_rdata(d3IfRdata),
    .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_gnt(d3DmGnt), .dm_rvalid(d3DmRvalid), .dm_rdata(d3DmRdata),
    .mem_en(d3MemEn), .mem_we(d3MemWe), .mem_addr(d3MemAddr), .mem_wdata(d3MemWdata),
    .mem_rdata(d3MemRdata), .busy(d3Busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared memory array; both instances issue identical writes, so one writer suffices.
  always @(posedge clk) begin
    if (d1MemEn && d1MemWe) mem[d1MemAddr] <= d1MemWdata;
  end

  // One-cycle read port for the latency-1 instance.
  always @(posedge clk) begin
    d1MemRdata <= (d1MemEn && !d1MemWe) ? mem[d1MemAddr] : 32'h0;
  end

  // Three-cycle read port for the latency-3 instance.
  always @(posedge clk) begin
    d3Pipe[0] <= (d3MemEn && !d3MemWe) ? mem[d3MemAddr] : 32'h0;
    d3Pipe[1] <= d3Pipe[0];
    d3Pipe[2] <= d3Pipe[1];
  end
  assign d3MemRdata = d3Pipe[2];

  task automatic idleInputs();
    ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
    dmReq = 1'b0; dmWe = 1'b0; dmAddr = '0; dmWdata = '0;
  endtask

  task automatic storeWord(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk);
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = addr; dmWdata = data;
    @(negedge clk);
    idleInputs();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    idleInputs();
    rstN = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    flags = {d1MemEn, d1Busy, d1IfRvalid, d1DmRvalid, d3Busy};
    nChecks++;
    if (flags !== 5'b0) begin
      nFails++; $display("[TB] FAIL reset_flags: got %b expected 00000", flags);
    end
    nChecks++;
    if ((d1IfRdata | d1DmRdata) !== 32'h0) begin
      nFails++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", d1IfRdata, d1DmRdata);
    end
    rstN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      flags = {d1MemEn, d1Busy, d1IfRvalid, d1DmRvalid, d3Busy};
      nChecks++;
      if (flags !== 5'b0) begin
        nFails++; $display("[TB] FAIL idle_cycle%0d: got %b expected 00000", c, flags);
      end
    end
  endtask

  task automatic test_fetch_only();
    storeWord(10'd5, 32'h2800_0005);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 10'd5; #1;
    nChecks++;
    if ({d1IfGnt, d1DmGnt, d1MemEn, d1MemWe} !== 4'b1010) begin
      nFails++; $display("[TB] FAIL fetch_gnt: got %b expected 1010", {d1IfGnt, d1DmGnt, d1MemEn, d1MemWe});
    end
    nChecks++;
    if (d1MemAddr !== 10'd5) begin
      nFails++; $display("[TB] FAIL fetch_addr: got %0d expected 5", d1MemAddr);
    end
    @(negedge clk);
    ifReq = 1'b0; #1;
    nChecks++;
    if ({d1IfRvalid, d1DmRvalid, d1Busy} !== 3'b101) begin
      nFails++; $display("[TB] FAIL fetch_rvalid: got %b expected 101", {d1IfRvalid, d1DmRvalid, d1Busy});
    end
    nChecks++;
    if (d1IfRdata !== 32'h2800_0005) begin
      nFails++; $display("[TB] FAIL fetch_rdata: got %h expected 28000005", d1IfRdata);
    end
    idleCycles(4);
  endtask

  task automatic test_contention();
    storeWord(10'd3, 32'h1111_0003);
    storeWord(10'd100, 32'hAAAA_0064);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 10'd3;
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 10'd100; #1;
    nChecks++;
    if ({d1DmGnt, d1IfGnt} !== 2'b10) begin
      nFails++; $display("[TB] FAIL contend_first: got dm/if %b expected 10", {d1DmGnt, d1IfGnt});
    end
    @(negedge clk);
    dmReq = 1'b0; #1;
    nChecks++;
    if ({d1DmGnt, d1IfGnt, d1DmRvalid, d1IfRvalid} !== 4'b0110) begin
      nFails++; $display("[TB] FAIL contend_second: got %b expected 0110", {d1DmGnt, d1IfGnt, d1DmRvalid, d1IfRvalid});
    end
    nChecks++;
    if (d1DmRdata !== 32'hAAAA_0064) begin
      nFails++; $display("[TB] FAIL contend_dm_rdata: got %h expected aaaa0064", d1DmRdata);
    end
    @(negedge clk);
    ifReq = 1'b0; #1;
    nChecks++;
    if ({d1DmRvalid, d1IfRvalid} !== 2'b01 || d1IfRdata !== 32'h1111_0003) begin
      nFails++; $display("[TB] FAIL contend_if_rdata: got v=%b d=%h expected 01/11110003", {d1DmRvalid, d1IfRvalid}, d1IfRdata);
    end
    idleCycles(4);
  endtask

  task automatic test_store_load();
    @(negedge clk);
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 10'd200; dmWdata = 32'hDEAD_BEEF; #1;
    nChecks++;
    if ({d1DmGnt, d1MemEn, d1MemWe} !== 3'b111 || d1MemWdata !== 32'hDEAD_BEEF || d1MemAddr !== 10'd200) begin
      nFails++; $display("[TB] FAIL store_cmd: got %b %h %0d expected 111 deadbeef 200", {d1DmGnt, d1MemEn, d1MemWe}, d1MemWdata, d1MemAddr);
    end
    @(negedge clk);
    dmWe = 1'b0; dmWdata = '0; #1;
    nChecks++;
    if ({d1DmGnt, d1MemEn, d1MemWe} !== 3'b110) begin
      nFails++; $display("[TB] FAIL load_cmd: got %b expected 110", {d1DmGnt, d1MemEn, d1MemWe});
    end
    @(negedge clk);
    dmReq = 1'b0; #1;
    nChecks++;
    if (d1DmRvalid !== 1'b1 || d1DmRdata !== 32'hDEAD_BEEF || d1MemWe !== 1'b0) begin
      nFails++; $display("[TB] FAIL store_load_data: got v=%b d=%h we=%b expected 1 deadbeef 0", d1DmRvalid, d1DmRdata, d1MemWe);
    end
    idleCycles(4);
  endtask

  task automatic test_flush();
    logic expV;
    storeWord(10'd10, 32'h0000_AA10);
    storeWord(10'd40, 32'h0000_BB40);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 10'd10; #1;
    nChecks++;
    if (d3IfGnt !== 1'b1) begin
      nFails++; $display("[TB] FAIL flush_gnt10: got %b expected 1", d3IfGnt);
    end
    @(negedge clk);
    ifAddr = 10'd40; ifFlush = 1'b1; #1;
    nChecks++;
    if (d3IfGnt !== 1'b1 || d3MemAddr !== 10'd40) begin
      nFails++; $display("[TB] FAIL flush_gnt40: got %b addr %0d expected 1 addr 40", d3IfGnt, d3MemAddr);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idleInputs(); #1;
      expV = (k == 3);
      nChecks++;
      if (d3IfRvalid !== expV) begin
        nFails++; $display("[TB] FAIL flush_rvalid_c%0d: got %b expected %b", k, d3IfRvalid, expV);
      end
      if (k == 3) begin
        nChecks++;
        if (d3IfRdata !== 32'h0000_BB40) begin
          nFails++; $display("[TB] FAIL flush_rdata: got %h expected 0000bb40", d3IfRdata);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 10'd10; #1;
    nChecks++;
    if (d3IfGnt !== 1'b1) begin
      nFails++; $display("[TB] FAIL midrst_gnt: got %b expected 1", d3IfGnt);
    end
    @(negedge clk);
    ifReq = 1'b0; rstN = 1'b0; #1;
    nChecks++;
    if ({d3Busy, d1Busy, d1IfRvalid} !== 3'b000) begin
      nFails++; $display("[TB] FAIL midrst_clear: got %b expected 000", {d3Busy, d1Busy, d1IfRvalid});
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      nChecks++;
      if ({d3IfRvalid, d1IfRvalid} !== 2'b00) begin
        nFails++; $display("[TB] FAIL midrst_rvalid_c%0d: got %b expected 00", k, {d3IfRvalid, d1IfRvalid});
      end
    end
  endtask

  task automatic test_starvation();
    logic expIf;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      dmReq = 1'b1; dmWe = 1'b0; dmAddr = 10'd7;
      ifReq = 1'b1; ifAddr = 10'd8; #1;
`ifdef MIPS32_ARB_STARVE_GUARD_EN
      expIf = (k == 5);
`else
      expIf = 1'b0;
`endif
      nChecks++;
      if ({d1IfGnt, d1DmGnt} !== {expIf, ~expIf}) begin
        nFails++; $display("[TB] FAIL starve_c%0d: got if/dm %b expected %b", k, {d1IfGnt, d1DmGnt}, {expIf, ~expIf});
      end
    end
    @(negedge clk);
    idleInputs();
    idleCycles(4);
  endtask

  initial begin
    idleInputs();
    rstN = 1'b0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_flush();
    test_reset_midflight();
    test_starvation();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
